// File: rtl/eject_merger_pkg.sv
// ---------------------------------------------------------------------------
// eject_merger_pkg
// Purpose : Shared definitions for the NoC eject merger and its neighbours
//           (injector, benches): flit-type encoding, type-field placement
//           and the merger FSM state type.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package eject_merger_pkg;

    // Flit type lives in the two most significant bits of every flit.
    typedef enum logic [1:0] {
        FlitBody   = 2'b00,
        FlitHead   = 2'b01,
        FlitTail   = 2'b10,
        FlitSingle = 2'b11
    } flit_type_e;

    localparam int unsigned FlitTypeW = 2;

    // Bit positions of the type field for a flit of width dw.
    function automatic int unsigned flit_type_msb(input int unsigned dw);
        return dw - 1;
    endfunction

    function automatic int unsigned flit_type_lsb(input int unsigned dw);
        return dw - FlitTypeW;
    endfunction

    typedef enum logic {
        StIdle   = 1'b0,
        StLocked = 1'b1
    } merger_state_e;

endpackage

// File: rtl/merger_fifo2.sv
// ---------------------------------------------------------------------------
// merger_fifo2
// Purpose : Two-entry registered FIFO. The head entry is driven straight
//           from storage, so a word pushed at edge N is visible after edge N.
// Ports   : clk, rstn (async active-low)
//           i_push / i_data : write strobe and word
//           i_pop           : read strobe (ignored when empty)
//           o_data / o_valid: head word and non-empty flag
//           o_full          : both entries occupied
// ---------------------------------------------------------------------------
module merger_fifo2 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic         o_full
);

    logic [W-1:0] r_mem [0:1];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_count;

    logic         w_push;
    logic         w_pop;
    logic [1:0]   w_count_d;

    always_comb begin
        w_push    = i_push && (r_count != 2'd2);
        w_pop     = i_pop && (r_count != 2'd0);
        // Push and pop together leave the occupancy unchanged.
        w_count_d = r_count;
        if (w_push && !w_pop) begin
            w_count_d = r_count + 2'd1;
        end else if (w_pop && !w_push) begin
            w_count_d = r_count - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= w_count_d;
        end
    end

    always_comb begin
        o_data  = r_mem[r_rptr];
        o_valid = (r_count != 2'd0);
        o_full  = (r_count == 2'd2);
    end

endmodule

// File: rtl/eject_merger.sv
// ---------------------------------------------------------------------------
// eject_merger
// Purpose : Merges EPN NoC eject ports into one flit stream. Ports are served
//           round-robin; once a head flit is taken the chosen port is locked
//           until its tail passes, so packets never interleave. Accepted
//           flits and their source index go through a 2-entry FIFO.
// Ports   : clk, rstn (async active-low)
//           data_i[EPN][DW], valid_i[EPN], ready_o[EPN] : eject-port side
//           data_o[DW], valid_o, ready_i, src_o         : merged stream
//           stall_err_o : sticky watchdog error
// Config  : define EJECT_MERGER_WATCHDOG_EN to build the locked-stall
//           watchdog; otherwise stall_err_o is tied low.
// ---------------------------------------------------------------------------
module eject_merger
    import eject_merger_pkg::*;
#(
    parameter int unsigned EPN      = 3,
    parameter int unsigned DW       = 32,
    parameter int unsigned WD_LIMIT = 10000
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [EPN-1:0][DW-1:0]        data_i,
    input  logic [EPN-1:0]                valid_i,
    output logic [EPN-1:0]                ready_o,
    output logic [DW-1:0]                 data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [((EPN > 1) ? $clog2(EPN) : 1)-1:0] src_o,
    output logic                          stall_err_o
);

    localparam int unsigned SW      = (EPN > 1) ? $clog2(EPN) : 1;
    localparam int unsigned TypeMsb = flit_type_msb(DW);
    localparam int unsigned TypeLsb = flit_type_lsb(DW);

    merger_state_e r_state, w_state_d;
    logic [SW-1:0] r_ptr, w_ptr_d;
    logic [SW-1:0] r_grant, w_grant_d;

    logic [SW-1:0] w_sel;
    logic          w_sel_vld;
    logic          w_fifo_full;
    logic          w_acc;
    logic [SW-1:0] w_acc_idx;
    logic [DW-1:0] w_acc_data;
    flit_type_e    w_acc_type;
    logic          w_pop;

    // Round-robin pick: first valid port strictly after r_ptr, wrapping.
    always_comb begin
        w_sel     = '0;
        w_sel_vld = 1'b0;
        for (int unsigned i = 1; i <= EPN; i++) begin
            int unsigned idx;
            idx = (int'(r_ptr) + i) % EPN;
            if (!w_sel_vld && valid_i[idx]) begin
                w_sel     = SW'(idx);
                w_sel_vld = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= StIdle;
            r_ptr   <= SW'(EPN - 1);
            r_grant <= '0;
        end else begin
            r_state <= w_state_d;
            r_ptr   <= w_ptr_d;
            r_grant <= w_grant_d;
        end
    end

    // Output logic: ready depends only on state, valid_i and FIFO occupancy.
    always_comb begin
        ready_o = '0;
        unique case (r_state)
            StIdle: begin
                if (w_sel_vld && !w_fifo_full) begin
                    ready_o[w_sel] = 1'b1;
                end
            end
            StLocked: begin
                if (!w_fifo_full) begin
                    ready_o[r_grant] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_acc      = |(ready_o & valid_i);
        w_acc_idx  = (r_state == StIdle) ? w_sel : r_grant;
        w_acc_data = data_i[w_acc_idx];
        w_acc_type = flit_type_e'(w_acc_data[TypeMsb:TypeLsb]);
    end

    // Next-state logic.
    always_comb begin
        w_state_d = r_state;
        w_ptr_d   = r_ptr;
        w_grant_d = r_grant;
        unique case (r_state)
            StIdle: begin
                if (w_acc) begin
                    if (w_acc_type == FlitHead) begin
                        w_state_d = StLocked;
                        w_grant_d = w_sel;
                    end else begin
                        w_ptr_d = w_sel;
                    end
                end
            end
            StLocked: begin
                if (w_acc && (w_acc_type == FlitTail)) begin
                    w_state_d = StIdle;
                    w_ptr_d   = r_grant;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign w_pop = valid_o && ready_i;

    merger_fifo2 #(
        .W (SW + DW)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_acc),
        .i_data  ({w_acc_idx, w_acc_data}),
        .i_pop   (w_pop),
        .o_data  ({src_o, data_o}),
        .o_valid (valid_o),
        .o_full  (w_fifo_full)
    );

`ifdef EJECT_MERGER_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(WD_LIMIT + 1);

    logic [WdW-1:0] r_wd_cnt, w_wd_cnt_d;
    logic           r_stall_err, w_stall_err_d;

    // Counts locked cycles where the granted port has nothing to offer;
    // saturates at the limit so the error flag stays meaningful.
    always_comb begin
        w_wd_cnt_d = r_wd_cnt;
        if (w_acc) begin
            w_wd_cnt_d = '0;
        end else if ((r_state == StLocked) && !valid_i[r_grant]
                     && (r_wd_cnt != WdW'(WD_LIMIT))) begin
            w_wd_cnt_d = r_wd_cnt + WdW'(1);
        end
        w_stall_err_d = r_stall_err || (w_wd_cnt_d == WdW'(WD_LIMIT));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wd_cnt    <= '0;
            r_stall_err <= 1'b0;
        end else begin
            r_wd_cnt    <= w_wd_cnt_d;
            r_stall_err <= w_stall_err_d;
        end
    end

    assign stall_err_o = r_stall_err;
`else
    assign stall_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_eject_merger.sv
module tb_eject_merger;
    import eject_merger_pkg::*;

    localparam int unsigned EPN = 3;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = 2;
`ifdef EJECT_MERGER_WATCHDOG_EN
    localparam logic WdOn = 1'b1;
`else
    localparam logic WdOn = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rstn;
    logic [EPN-1:0][DW-1:0] data_i;
    logic [EPN-1:0]         valid_i;
    logic [EPN-1:0]         ready_o;
    logic [DW-1:0]          data_o;
    logic                   valid_o;
    logic                   ready_i;
    logic [SW-1:0]          src_o;
    logic                   stall_err_o;

    always #5 clk = ~clk;

    eject_merger #(
        .EPN      (EPN),
        .DW       (DW),
        .WD_LIMIT (16)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .src_o       (src_o),
        .stall_err_o (stall_err_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [DW-1:0]    pq [EPN][$];   // per-port flits still to be offered
    logic [SW+DW-1:0] exp_q [$];     // {src, data} in required output order

    int mdl_cnt  = 0;                // FIFO occupancy from observed handshakes
    int cyc      = 0;
    int t_in     = -1;
    int t_out    = -1;
    int rdy1_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Port drivers and output monitor: sample at negedge, drive #1 after posedge.
    always begin : drv
        logic [EPN-1:0]   in_fire;
        logic             out_fire;
        logic [SW+DW-1:0] e;
        @(negedge clk);
        cyc++;
        in_fire  = valid_i & ready_o;
        out_fire = valid_o & ready_i;
        if (rstn) begin
            if (mdl_cnt >= 2) chk("full_ready_low", 64'(ready_o), 64'(0));
            if (in_fire[1] && t_in < 0) t_in = cyc;
            if (valid_o && t_out < 0) t_out = cyc;
            if (ready_o[1]) rdy1_cnt++;
            if (out_fire) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 64'(valid_o), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 64'(data_o), 64'(e[DW-1:0]));
                    chk("out_src", 64'(src_o), 64'(e[SW+DW-1:DW]));
                end
            end
        end
        @(posedge clk);
        #1;
        if (!rstn) mdl_cnt = 0;
        else mdl_cnt += $countones(in_fire) - int'(out_fire);
        for (int p = 0; p < EPN; p++) begin
            if (rstn && in_fire[p] && pq[p].size() != 0) void'(pq[p].pop_front());
            valid_i[p] = (pq[p].size() != 0);
            data_i[p]  = (pq[p].size() != 0) ? pq[p][0] : '0;
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rstn = 1'b0;
        for (int p = 0; p < EPN; p++) pq[p].delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic send(input int p, input logic [DW-1:0] d);
        pq[p].push_back(d);
        exp_q.push_back({SW'(p), d});
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        chk(tag, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        rstn    = 1'b0;
        ready_i = 1'b0;
        valid_i = '0;
        data_i  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_o", 64'(valid_o), 64'(0));
        chk("rst_ready_o", 64'(ready_o), 64'(0));
        chk("rst_data_o", 64'(data_o), 64'(0));
        chk("rst_src_o", 64'(src_o), 64'(0));
        chk("rst_stall", 64'(stall_err_o), 64'(0));

        // Single flit on port 1.
        apply_reset();
        ready_i  = 1'b1;
        t_in     = -1;
        t_out    = -1;
        rdy1_cnt = 0;
        send(1, 32'hC000_0001);
        wait_drain(20, "single_drain");
        chk("single_latency", 64'(t_out - t_in), 64'(1));
        chk("single_ready_cycles", 64'(rdy1_cnt), 64'(1));

        // Two simultaneous 3-flit packets on ports 0 and 2.
        apply_reset();
        ready_i = 1'b1;
        send(0, 32'h4000_0A01);
        send(0, 32'h0000_0A02);
        send(0, 32'h8000_0A03);
        send(2, 32'h4000_0C01);
        send(2, 32'h0000_0C02);
        send(2, 32'h8000_0C03);
        wait_drain(40, "pkt_drain");

        // Singles on all ports: round-robin 0,1,2,0,1,2.
        apply_reset();
        ready_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < EPN; p++) begin
                send(p, 32'hC000_0000 | 32'(p << 4) | 32'(k));
            end
        end
        wait_drain(40, "rr_drain");

        // 1000-flit stream with ready_i toggling every 50 cycles.
        apply_reset();
        ready_i = 1'b1;
        for (int i = 0; i < 1000; i++) send(1, {2'b11, 30'(i * 7 + 3)});
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
            repeat (50) @(posedge clk);
            #1;
            ready_i = ~ready_i;
        end
        ready_i = 1'b1;
        wait_drain(100, "stream_drain");

        // Head with no tail: watchdog.
        apply_reset();
        ready_i = 1'b1;
        send(0, 32'h4000_00AA);
        repeat (9) @(posedge clk);
        #1;
        chk("wd_before_limit", 64'(stall_err_o), 64'(0));
        chk("wd_head_out", 64'(exp_q.size()), 64'(0));
        repeat (13) @(posedge clk);
        #1;
        chk("wd_after_limit", 64'(stall_err_o), 64'(WdOn));
        repeat (10) @(posedge clk);
        #1;
        chk("wd_sticky", 64'(stall_err_o), 64'(WdOn));

        // Reset after a head is accepted.
        apply_reset();
        ready_i = 1'b0;
        send(0, 32'h4000_00BB);
        for (int n = 0; n < 20 && pq[0].size() != 0; n++) @(posedge clk);
        chk("rst_head_accepted", 64'(pq[0].size()), 64'(0));
        @(negedge clk);
        chk("rst_head_held", 64'(valid_o), 64'(1));
        #2;
        rstn = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_valid_o", 64'(valid_o), 64'(0));
        chk("midrst_data_o", 64'(data_o), 64'(0));
        chk("midrst_src_o", 64'(src_o), 64'(0));
        chk("midrst_stall", 64'(stall_err_o), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rstn    = 1'b1;
        ready_i = 1'b1;
        send(2, 32'hC000_00CC);
        wait_drain(20, "post_rst_drain");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/eject_merger.md
EJECT_MERGER -- requirements
Module: eject_merger

Interface
REQ-001 Parameter EPN, default 3, number of NoC eject ports merged.
REQ-002 Parameter DW, default 32, flit width in bits.
REQ-003 Parameter WD_LIMIT, default 10000, watchdog cycle limit.
REQ-004 Reset rstn, asynchronous, active-low; clock clk.
REQ-005 clk  input  1  clock.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 data_i  input  [EPN][DW]  eject-port flits from the NoC.
REQ-008 valid_i  input  [EPN]  flit valid per eject port.
REQ-009 ready_o  output  [EPN]  flit accept per eject port.
REQ-010 data_o  output  DW  merged flit stream.
REQ-011 valid_o  output  1  merged flit valid.
REQ-012 ready_i  input  1  sink accept.
REQ-013 src_o  output  $clog2(EPN)  source eject port of the flit on data_o.
REQ-014 stall_err_o  output  1  sticky watchdog error.

Function
REQ-015 Flit type SHALL be data[DW-1:DW-2]: 00 body, 01 head, 10 tail, 11 single.
REQ-016 A flit SHALL transfer on an input or output port only when valid and ready are both high at posedge clk.
REQ-017 The FSM SHALL have two states, IDLE and LOCKED.
REQ-018 In IDLE, the block SHALL round-robin select the first valid port after the last-granted port (ptr), then assert ready_o only for that port, and only when the FIFO is not full.
REQ-019 In IDLE, acceptance of a head flit SHALL move the FSM to LOCKED, with grant set to the selected port.
REQ-020 In IDLE, acceptance of a single, body or tail flit SHALL leave the FSM in IDLE and set ptr to the selected port; the flit SHALL be forwarded unchanged.
REQ-021 In LOCKED, only ready_o[grant] may be high, gated by FIFO not full; every other ready_o SHALL be 0.
REQ-022 In LOCKED, acceptance of a tail flit SHALL return the FSM to IDLE and set ptr to grant.
REQ-023 Accepted flits SHALL enter a 2-entry FIFO together with their source index; data_o, src_o and valid_o SHALL be driven from the FIFO head.
REQ-024 Latency SHALL be exactly 1 cycle: a flit accepted at edge N is visible on data_o after edge N.
REQ-025 Throughput SHALL be 1 flit/cycle while ready_i is held high.
REQ-026 ready_o SHALL depend only on registered state and valid_i (FIFO count<2), never on ready_i.
REQ-027 A simultaneous push and pop SHALL leave the FIFO count unchanged.
REQ-028 When the FIFO is full, all ready_o SHALL be 0.
REQ-029 The round-robin pointer SHALL wrap from EPN-1 to 0.
REQ-030 Flits from different packets SHALL never interleave on data_o.

Reset
REQ-031 rstn low SHALL force the FSM to IDLE, ptr=EPN-1, FIFO empty, valid_o=0, ready_o=0, data_o=0, src_o=0, stall_err_o=0 and watchdog count 0, asynchronously.
REQ-032 Reset mid-packet SHALL discard the FIFO contents and any partial lock.

Configuration
REQ-033 Macro EJECT_MERGER_WATCHDOG_EN SHALL gate the watchdog feature.
REQ-034 When the macro is defined: a counter SHALL increment each cycle in LOCKED with valid_i[grant]=0 and SHALL clear on any accepted flit; when it reaches WD_LIMIT, stall_err_o SHALL be set and held until reset.
REQ-035 When the macro is undefined, no counter SHALL exist and stall_err_o SHALL be tied to 0.

Structure
REQ-036 A shared package SHALL hold the flit-type enum (BODY, HEAD, TAIL, SINGLE) and the type-field bit positions, for reuse by the injector and test benches.
REQ-037 The 2-entry FIFO SHALL be a sub-module, merger_fifo2, parameterised by width.

Verification
REQ-038 Bench SHALL cover: single flit 0xC0000001 on port 1, ready_i=1 -> data_o=0xC0000001 and src_o=1 one cycle later, ready_o[1] high for 1 cycle.
REQ-039 Bench SHALL cover: ports 0 and 2 each send a 3-flit packet (head/body/tail) simultaneously -> all port-0 flits out first, then all port-2 flits, with no interleave.
REQ-040 Bench SHALL cover: all 3 ports continuously send singles -> src_o sequence 0,1,2,0,1,2 (round-robin wrap).
REQ-041 Bench SHALL cover: ready_i toggling every 50 cycles during a 1000-flit stream -> no flit lost or duplicated, and ready_o=0 whenever the FIFO count is 2.
REQ-042 Bench SHALL cover (macro on, WD_LIMIT=16): head flit on port 0 followed by no tail for 16 cycles -> stall_err_o=1 and sticky; (macro off) -> stall_err_o stays 0.
REQ-043 Bench SHALL cover: rstn asserted after a head flit is accepted -> valid_o=0 immediately, FSM IDLE, and the next single flit on port 2 is accepted normally after release.
